// File: rtl/wide_adder_pkg.sv
// wide_adder_pkg: shared slice width, sequencer state encoding and index-width helper.
package wide_adder_pkg;
  localparam int WORD_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wide_adder_seq_cla.sv
// wide_adder_seq_cla: 8-bit carry-lookahead adder slice; each carry is a flat sum of generate/propagate products.
module wide_adder_seq_cla
  import wide_adder_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              c_i,
  output logic [WORD_W-1:0] s_o,
  output logic              c_o
);
  logic [WORD_W-1:0] g, p;
  logic [WORD_W:0] c;
  logic pr, acc;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  always_comb begin
    c = '0;
    pr = 1'b1;
    acc = 1'b0;
    for (int i = 0; i <= WORD_W; i++) begin
      pr = 1'b1;
      acc = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (g[j] & pr);
        pr = pr & p[j];
      end
      c[i] = acc | (c_i & pr);
    end
  end
  assign s_o = p ^ c[WORD_W-1:0];
  assign c_o = c[WORD_W];
endmodule

// File: rtl/wide_adder_seq.sv
// wide_adder_seq: wide add/sub sequenced one 8-bit word per cycle through a single CLA slice.
// Defining WIDE_ADDER_SEQ_OVF_EN adds the signed-overflow output ovf_o.
module wide_adder_seq
  import wide_adder_pkg::*;
#(
  parameter int N_WORDS = 4,
  localparam int W = WORD_W * N_WORDS,
  localparam int IW = idx_w(N_WORDS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  input  logic         sub_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] sum_o,
  output logic         c_o
`ifdef WIDE_ADDER_SEQ_OVF_EN
  ,
  output logic         ovf_o
`endif
);
  state_e state_q, state_d;
  logic [N_WORDS-1:0][WORD_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic carry_q, carry_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] s;
  logic co, acc, last;
  assign acc = valid_i && state_q == IDLE;
  assign last = idx_q == IW'(N_WORDS - 1);
  wide_adder_seq_cla u_cla (
    .a_i(a_q[idx_q]),
    .b_i(b_q[idx_q]),
    .c_i(carry_q),
    .s_o(s),
    .c_o(co)
  );
  // Subtraction is folded into the operand register: B is stored inverted with a carry seed of 1.
  always_comb begin
    state_d = state_q;
    a_d = acc ? a_i : a_q;
    b_d = acc ? (sub_i ? ~b_i : b_i) : b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    idx_d = idx_q;
    if (acc) begin
      state_d = RUN;
      carry_d = sub_i | c_i;
      idx_d = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q] = s;
      carry_d = co;
      idx_d = idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      idx_q <= idx_d;
    end
  end
  assign ready_o = state_q == IDLE;
  assign valid_o = state_q == DONE;
  assign sum_o = sum_q;
  assign c_o = carry_q;
`ifdef WIDE_ADDER_SEQ_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf_d = (state_q == RUN && last)
    ? (a_q[N_WORDS-1][WORD_W-1] == b_q[N_WORDS-1][WORD_W-1]) && (s[WORD_W-1] != a_q[N_WORDS-1][WORD_W-1])
    : ovf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf_o = ovf_q;
`endif
endmodule

// File: tb/tb_wide_adder_seq.sv
// tb_wide_adder_seq: directed vectors for the 4-word sequencer with hand-computed results.
module tb_wide_adder_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic valid_i = 1'b0, ready_i = 1'b0, c_i = 1'b0, sub_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic ready_o, valid_o, c_o;
  logic [31:0] sum_o;
  int n_chk = 0, n_err = 0;
`ifdef WIDE_ADDER_SEQ_OVF_EN
  logic ovf_o;
`endif
  wide_adder_seq #(.N_WORDS(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .a_i(a_i),
    .b_i(b_i),
    .c_i(c_i),
    .sub_i(sub_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .sum_o(sum_o),
    .c_o(c_o)
`ifdef WIDE_ADDER_SEQ_OVF_EN
    ,
    .ovf_o(ovf_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    a_i = a; b_i = b; c_i = c; sub_i = s; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask
  task automatic wait_res(input string tag, input logic [31:0] es, input logic ec);
    int cyc = 0;
    while (!valid_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd4);
    chk({tag, "_sum"}, 64'(sum_o), 64'(es));
    chk({tag, "_c"}, 64'(c_o), 64'(ec));
  endtask
  task automatic take(input string tag);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({tag, "_rdy"}, 64'(ready_o), 64'd1);
    chk({tag, "_vld"}, 64'(valid_o), 64'd0);
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                        input logic [31:0] es, input logic ec);
    send(a, b, c, s);
    wait_res(tag, es, ec);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(ready_o), 64'd1);
    chk("rst_vld", 64'(valid_o), 64'd0);
    chk("rst_sum", 64'(sum_o), 64'd0);
    chk("rst_c", 64'(c_o), 64'd0);
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("rst_ovf", 64'(ovf_o), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("inc", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("inc_ovf", 64'(ovf_o), 64'd0);
`endif
    take("inc");
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
    take("ripple");
    run_op("sub57", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    take("sub57");
    run_op("sub75", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
    take("sub75");
    run_op("povf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("povf_ovf", 64'(ovf_o), 64'd1);
`endif
    take("povf");
    run_op("novf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1);
`ifdef WIDE_ADDER_SEQ_OVF_EN
    chk("novf_ovf", 64'(ovf_o), 64'd1);
`endif
    take("novf");
    run_op("bp", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0);
    a_i = 32'h0000_0001; b_i = 32'h0000_0002; c_i = 1'b0; sub_i = 1'b0; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", 64'(valid_o), 64'd1);
      chk("bp_sum", 64'(sum_o), 64'h3333_3333);
      chk("bp_rdy", 64'(ready_o), 64'd0);
    end
    take("bp");
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("bp_acc", 64'(ready_o), 64'd0);
    wait_res("bp_next", 32'h0000_0003, 1'b0);
    take("bp_next");
    send(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rdy", 64'(ready_o), 64'd1);
    chk("mid_vld", 64'(valid_o), 64'd0);
    chk("mid_sum", 64'(sum_o), 64'd0);
    chk("mid_c", 64'(c_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_novld", 64'(valid_o), 64'd0);
    run_op("post", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0);
    take("post");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wide_adder_seq.md
# wide_adder_seq

Multi-cycle sequencer that performs wide (N_WORDS × 8-bit) addition or subtraction by time-multiplexing a single 8-bit carry-lookahead adder slice, one word per clock, least-significant word first. It accepts an operand pair over a valid/ready handshake, walks the word slices while holding the inter-word carry in a register, and presents the full result over a second valid/ready handshake. It sits between an operand source (register file / test driver) and a result consumer. It lets the team reuse the existing 8-bit adder for arbitrary widths without replicating it.

## Interface
- N_WORDS, default 4: number of 8-bit slices; operand width W = 8·N_WORDS; legal range 2..16.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  operand request valid.
- ready_o  out  1  block can accept a request.
- a_i  in  W  operand A.
- b_i  in  W  operand B.
- c_i  in  1  carry-in for addition; ignored when sub_i=1.
- sub_i  in  1  0: A+B+c_i; 1: A−B, computed as A+~B+1.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- sum_o  out  W  result.
- c_o  out  1  carry-out of the MSB slice; for subtraction, 1 means no borrow.
- ovf_o  out  1  signed overflow. Present only with WIDE_ADDER_SEQ_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o: register a_i, b_i (inverted if sub_i), and carry seed (sub_i ? 1 : c_i).
  - Clear word index idx to 0; go to RUN.
- RUN:
  - Each cycle, the slice adds A[idx], B'[idx] and carry_q.
  - The slice sum is written into sum register word idx; its carry-out is stored in carry_q; idx increments.
  - When idx==N_WORDS−1 has been processed, go to DONE.
- DONE:
  - valid_o=1; sum_o and c_o are held stable.
  - On valid_o&&ready_i, go to IDLE.
- ready_o is 1 only in IDLE and valid_o is 1 only in DONE, so accept and deliver can never occur in the same cycle.
- Inputs a_i, b_i, c_i and sub_i are sampled only at the accept edge. Changes during RUN or DONE have no effect.
- valid_i asserted outside IDLE is ignored; the source must hold the request until it sees ready_o.
- ready_i asserted before valid_o has no effect.
- Arithmetic is modulo 2^W. c_o is bit W of the full result.
- sum_o words not yet computed hold their previous values during RUN and are not meaningful until valid_o.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, sum_o=0, c_o=0, ovf_o=0, idx=0, carry_q=0.
- Reset is effective immediately (asynchronous) in any state, including mid-RUN and while DONE awaits ready_i. The in-flight operation is discarded with no result emitted.
- Latency: if the request is accepted at edge k, valid_o rises after edge k+N_WORDS (N_WORDS RUN cycles).
- With ready_i held high, the result is consumed at edge k+N_WORDS+1 and ready_o is high again in the following cycle.
- Throughput: one operation per N_WORDS+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- WIDE_ADDER_SEQ_OVF_EN defined:
  - Port ovf_o exists, registered at the last RUN cycle.
  - ovf_o = (A[W−1]==B'[W−1]) && (sum[W−1]!=A[W−1]).
  - Valid while valid_o=1; cleared on reset.
- Undefined: port ovf_o and its logic are absent; all other behaviour is identical.

## Structure
- Shared package wide_adder_pkg holds:
  - WORD_W=8.
  - The FSM state enum (IDLE, RUN, DONE).
  - The index-width function clog2-based on N_WORDS.
- Sub-module: the team's existing 8-bit carry-lookahead adder, instantiated once as the slice datapath. The sequencer contains only control, operand/result registers and carry_q.

## Test plan
- N_WORDS=4, 0x000000FF + 0x00000001, c_i=0, sub_i=0 → sum_o=0x00000100, c_o=0; valid_o rises exactly 4 cycles after accept.
- 0xFFFFFFFF + 0x00000000, c_i=1 → sum_o=0x00000000, c_o=1. This checks carry ripple through all 4 slices.
- sub_i=1, 5 − 7, with c_i=1 (must be ignored) → sum_o=0xFFFFFFFE, c_o=0. Then 7 − 5 → sum_o=0x00000002, c_o=1.
- Overflow, macro defined: 0x7FFFFFFF + 1 → sum_o=0x80000000, ovf_o=1. 0x80000000 − 1 → 0x7FFFFFFF, ovf_o=1.
- Backpressure: ready_i low for 3 cycles in DONE → sum_o/valid_o stable, ready_o=0, and a new valid_i with changed operands is ignored. After ready_i, the next request is accepted one cycle later.
- Assert rst_i during RUN (idx=2) → immediately state IDLE, ready_o=1, valid_o=0, sum_o=0. A new request 0x10+0x20 then gives 0x30.
